// File: rtl/demux_14_reg_pkg.sv
// demux_14_reg_pkg: FSM encoding, select codes and default width for demux_14_reg
package demux_14_reg_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_e;
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;
  localparam int DATA_W = 4;
  function automatic logic [3:0] dec2to4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/demux_14_reg_if.sv
// demux_14_reg_if: request/ack write bus and destination outputs; bcast exists only with DEMUX_14_REG_BCAST_EN
interface demux_14_reg_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic             sel1;
  logic             sel0;
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             a_vld;
  logic             b_vld;
  logic             c_vld;
  logic             d_vld;
`ifdef DEMUX_14_REG_BCAST_EN
  logic             bcast;
`endif
  modport master (
    output din, sel1, sel0, req,
`ifdef DEMUX_14_REG_BCAST_EN
    output bcast,
`endif
    input ack, a, b, c, d, a_vld, b_vld, c_vld, d_vld
  );
  modport slave (
    input din, sel1, sel0, req,
`ifdef DEMUX_14_REG_BCAST_EN
    input bcast,
`endif
    output ack, a, b, c, d, a_vld, b_vld, c_vld, d_vld
  );
endinterface

// File: rtl/demux_14_reg_reg_4b_en.sv
// reg_4b_en: load-enable register with synchronous active-high reset
module reg_4b_en #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = en ? d : q_q;
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/demux_14_reg.sv
// demux_14_reg: registered 1-to-4 write demux over a four-phase req/ack handshake
// Optional broadcast to all four destinations with DEMUX_14_REG_BCAST_EN.
module demux_14_reg
  import demux_14_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic            clk,
  input logic            rst,
  demux_14_reg_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       dest, en, vld_q, vld_d;
  logic             ack_q, ack_d, accept;
  logic [WIDTH-1:0] q [4];
`ifdef DEMUX_14_REG_BCAST_EN
  logic             bcast_q, bcast_d;
`endif
  always_comb begin
    accept  = (state_q == IDLE) && bus.req;
    state_d = accept ? WRITE : (state_q == WRITE) ? DONE : (state_q == DONE && bus.req) ? DONE : IDLE;
    din_d   = accept ? bus.din : din_q;
    sel_d   = accept ? {bus.sel1, bus.sel0} : sel_q;
`ifdef DEMUX_14_REG_BCAST_EN
    bcast_d = accept ? bus.bcast : bcast_q;
    dest    = bcast_q ? 4'hF : dec2to4(sel_q);
`else
    dest    = dec2to4(sel_q);
`endif
    en      = (state_q == WRITE) ? dest : 4'h0;
    vld_d   = en;
    ack_d   = (state_q == WRITE) || (state_q == DONE && bus.req);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      sel_q   <= '0;
      vld_q   <= '0;
      ack_q   <= 1'b0;
`ifdef DEMUX_14_REG_BCAST_EN
      bcast_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
`ifdef DEMUX_14_REG_BCAST_EN
      bcast_q <= bcast_d;
`endif
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_dst
    reg_4b_en #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (en[g]),
      .d   (din_q),
      .q   (q[g])
    );
  end
  assign bus.a     = q[0];
  assign bus.b     = q[1];
  assign bus.c     = q[2];
  assign bus.d     = q[3];
  assign bus.a_vld = vld_q[0];
  assign bus.b_vld = vld_q[1];
  assign bus.c_vld = vld_q[2];
  assign bus.d_vld = vld_q[3];
  assign bus.ack   = ack_q;
endmodule

// File: tb/tb_demux_14_reg.sv
// tb_demux_14_reg: directed checks of routing, handshake, reset and broadcast behaviour
module tb_demux_14_reg;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  demux_14_reg_if #(.WIDTH(4)) bus ();
  demux_14_reg #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [15:0] regs();
    return {bus.d, bus.c, bus.b, bus.a};
  endfunction
  function automatic logic [3:0] vlds();
    return {bus.d_vld, bus.c_vld, bus.b_vld, bus.a_vld};
  endfunction
  task automatic drive(input logic [3:0] din, input logic [1:0] sel, input logic req);
    bus.din  = din;
    bus.sel1 = sel[1];
    bus.sel0 = sel[0];
    bus.req  = req;
  endtask
  initial begin
    rst = 1'b1;
    drive(4'hF, 2'b00, 1'b1);
`ifdef DEMUX_14_REG_BCAST_EN
    bus.bcast = 1'b0;
`endif
    step();
    step();
    chk("rst_regs", regs(), 16'h0000);
    chk("rst_vld", vlds(), 4'h0);
    chk("rst_ack", bus.ack, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_accept_ack", bus.ack, 1'b0);
    chk("post_rst_accept_a", bus.a, 4'h0);
    step();
    chk("post_rst_write_regs", regs(), 16'h000F);
    chk("post_rst_write_vld", vlds(), 4'b0001);
    chk("post_rst_write_ack", bus.ack, 1'b1);
    bus.req = 1'b0;
    step();
    chk("post_rst_release_ack", bus.ack, 1'b0);
    chk("post_rst_release_vld", vlds(), 4'h0);
    drive(4'h5, 2'b10, 1'b1);
    step();
    chk("route_c_accept_vld", vlds(), 4'h0);
    chk("route_c_accept_ack", bus.ack, 1'b0);
    step();
    chk("route_c_regs", regs(), 16'h050F);
    chk("route_c_vld", vlds(), 4'b0100);
    chk("route_c_ack", bus.ack, 1'b1);
    step();
    chk("route_c_vld_drop", vlds(), 4'h0);
    chk("route_c_ack_hold", bus.ack, 1'b1);
    bus.req = 1'b0;
    step();
    chk("route_c_ack_drop", bus.ack, 1'b0);
    drive(4'h3, 2'b01, 1'b1);
    step();
    drive(4'hC, 2'b11, 1'b1);
    step();
    chk("late_change_regs", regs(), 16'h053F);
    chk("late_change_vld", vlds(), 4'b0010);
    bus.req = 1'b0;
    step();
    drive(4'h7, 2'b01, 1'b1);
    step();
    step();
    chk("held_write_regs", regs(), 16'h057F);
    chk("held_write_vld", vlds(), 4'b0010);
    for (int i = 0; i < 10; i++) begin
      drive(4'h1, 2'b00, 1'b1);
      step();
      chk("held_ack", bus.ack, 1'b1);
      chk("held_no_vld", vlds(), 4'h0);
      chk("held_regs", regs(), 16'h057F);
    end
    bus.req = 1'b0;
    step();
    chk("held_release_ack", bus.ack, 1'b0);
    drive(4'h9, 2'b00, 1'b1);
    step();
    step();
    chk("pre_rst_done_regs", regs(), 16'h0579);
    chk("pre_rst_done_ack", bus.ack, 1'b1);
    rst = 1'b1;
    bus.req = 1'b0;
    step();
    chk("rst_done_regs", regs(), 16'h0000);
    chk("rst_done_ack", bus.ack, 1'b0);
    rst = 1'b0;
    drive(4'h6, 2'b11, 1'b1);
    step();
    step();
    chk("after_rst_regs", regs(), 16'h6000);
    chk("after_rst_vld", vlds(), 4'b1000);
    bus.req = 1'b0;
    step();
    drive(4'hA, 2'b00, 1'b1);
`ifdef DEMUX_14_REG_BCAST_EN
    bus.bcast = 1'b1;
`endif
    step();
`ifdef DEMUX_14_REG_BCAST_EN
    bus.bcast = 1'b0;
`endif
    step();
`ifdef DEMUX_14_REG_BCAST_EN
    chk("bcast_regs", regs(), 16'hAAAA);
    chk("bcast_vld", vlds(), 4'hF);
`else
    chk("no_bcast_regs", regs(), 16'h600A);
    chk("no_bcast_vld", vlds(), 4'b0001);
`endif
    bus.req = 1'b0;
    step();
    drive(4'h2, 2'b10, 1'b1);
    step();
    rst = 1'b1;
    bus.req = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_write_drop_regs", regs(), 16'h0000);
    chk("rst_write_drop_vld", vlds(), 4'h0);
    step();
    chk("rst_write_drop_idle_regs", regs(), 16'h0000);
    chk("rst_write_drop_idle_ack", bus.ack, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/demux_14_reg.md
# demux_14_reg

Registered 1-to-4 demultiplexer: the write-side counterpart of the 4:1 read-select muxes in the 4-bit CPU datapath. It accepts one WIDTH-bit word and a 2-bit destination select over a four-phase req/ack handshake. It writes the word into one of four holding registers (a, b, c, d) and pulses that destination's update strobe. It sits between the ALU/load result bus and the register bank.

## Interface
- WIDTH, 4, data width of din and of each destination register
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  WIDTH  write data, latched at request acceptance
- sel1  input  1  destination select MSB
- sel0  input  1  destination select LSB; {sel1,sel0}: 00→a, 01→b, 10→c, 11→d
- req  input  1  write request, four-phase; held high until ack seen
- ack  output  1  registered; high from commit until req drops
- a, b, c, d  output  WIDTH each  destination holding registers
- a_vld, b_vld, c_vld, d_vld  output  1 each  one-cycle strobe, high in the cycle the matching register shows new data
- bcast  input  1  broadcast request; only present with DEMUX_14_REG_BCAST_EN

## Operation
- The block is one clock domain. Reset is synchronous and active-high.
- FSM states:
  - IDLE: waiting for a request.
  - WRITE: committing the latched word.
  - DONE: ack high, waiting for req to fall.
- IDLE: when req=1 at a clk edge, latch din, {sel1,sel0} (and bcast if enabled) into hold registers, then go to WRITE. When req=0, stay in IDLE.
- WRITE: unconditional. At the next edge:
  - the selected destination register takes the held word;
  - its *_vld goes high;
  - ack goes high;
  - the FSM goes to DONE.
- DONE: the *_vld strobe drops after one cycle. ack stays high while req=1. When req=0 at an edge, ack drops and the FSM goes to IDLE.
- Each transaction writes exactly one destination, or four under broadcast. Unselected registers hold their value.
- din, sel1, sel0 and bcast are ignored outside the IDLE acceptance edge. Changes during WRITE or DONE have no effect.
- Return-to-zero is mandatory: a req held high after ack never starts a second write. req must be seen low, which moves the FSM to IDLE, before the next acceptance.
- Reset values: a=b=c=d=0, all *_vld=0, ack=0, FSM=IDLE, hold registers=0.

## Timing
- Edge 0: req sampled high in IDLE.
- Edge 1: the destination register updates, and its *_vld and ack are high in the cycle after edge 1. Write latency is 2 edges from acceptance.
- Edge 2: *_vld low. ack remains high until the edge after req is seen low.
- Minimum transaction is 4 cycles (accept, write, ack, IDLE).
- Reset mid-operation (rst=1 in WRITE or DONE): the FSM goes to IDLE and all outputs take their reset values at that edge. If rst coincides with the WRITE edge, the write is dropped (rst has priority).
- req high during rst is ignored. If req is still high on the first edge after rst deasserts, it is accepted as a new request.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- DEMUX_14_REG_BCAST_EN defined:
  - Adds the bcast input.
  - When bcast=1 at acceptance, WRITE loads the held word into all of a, b, c and d and pulses all four *_vld together. sel1/sel0 are ignored for that transaction.
- Undefined:
  - No bcast port and no broadcast hold bit.
  - Exactly one destination is written, per {sel1,sel0}.

## Structure
- Package demux_14_reg_pkg holds:
  - the FSM state encoding, IDLE=2'b00, WRITE=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE;
  - the select codes SEL_A..SEL_D = 2'b00..2'b11;
  - the default width constant DATA_W=4.
- Sub-module reg_4b_en, parameterised by WIDTH, is instantiated four times, once per destination. It is a load-enable register with synchronous active-high reset. The top level supplies the FSM, hold registers, 2-to-4 enable decode and vld/ack generation.

## Test plan
- Reset: drive rst=1 for 2 cycles with req=1 and din=4'hF → a..d=0, all vld=0, ack=0. After release, req=1 is accepted and a=4'hF two edges later.
- Basic route: din=4'h5, {sel1,sel0}=10, req pulse with four-phase handshake → c=4'h5, c_vld high exactly 1 cycle, ack rises 2 edges after acceptance, a/b/d unchanged.
- Input change after accept: accept din=4'h3 with sel=01, then drive din=4'hC and sel=11 during WRITE → b=4'h3, d unchanged.
- Held req: keep req=1 for 10 cycles after ack → exactly one write and one b_vld pulse, ack high for the whole time req is high.
- Reset in DONE: after writing a=4'h9, assert rst while ack=1 → ack=0, a=0, FSM idle. The next transaction writes normally.
- Broadcast (DEMUX_14_REG_BCAST_EN): bcast=1, din=4'hA, sel=00 → a=b=c=d=4'hA with all four vld pulsed in the same cycle. The bench builds without the macro → only a written.
